// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_ctrl
// Description : PS/2 device-to-host frame receiver. It takes debounced PS/2
//               clock and data lines, assembles 11-bit frames (start, 8 data
//               bits LSB first, odd parity, stop), and hands good bytes to a
//               valid/ready consumer through a one-entry holding register.
//               It also produces the sampling strobe that paces the external
//               debouncers, and aborts stalled frames after a strobe-counted
//               timeout.
// Ports       :
//   clk              in   system clock (rising edge)
//   rst_n            in   asynchronous active-low reset
//   ps2_clk_db       in   debounced PS/2 clock
//   ps2_data_db      in   debounced PS/2 data
//   deb_clock_enable out  one-cycle sampling strobe for the debouncers
//   rx_data[7:0]     out  received byte, valid while rx_valid is high
//   rx_valid         out  byte available, held until accepted
//   rx_ready         in   consumer accepts when rx_valid and rx_ready
//   rx_err           out  one-cycle error pulse
//   err_code[1:0]    out  00 overrun, 01 parity, 10 stop bit, 11 timeout
//   busy             out  high while a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_ctrl #(
    parameter int TICK_DIV      = 50,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_db,
    input  logic       ps2_data_db,
    output logic       deb_clock_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] C_TO_MAX    = TW'(TIMEOUT_TICKS);

    localparam logic [1:0] C_ERR_OVERRUN = 2'b00;
    localparam logic [1:0] C_ERR_PARITY  = 2'b01;
    localparam logic [1:0] C_ERR_STOP    = 2'b10;
    localparam logic [1:0] C_ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_ps2_clk_q;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_rx_err;
    logic [1:0]    r_err_code;

    logic          w_fall;
    logic          w_timeout;
    logic          w_frame_done;
    logic          w_abort;
    logic          w_parity_ok;
    logic          w_hold_free;

    // ------------------------------------------------------------------
    // Debouncer strobe prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= (r_presc == C_PRESC_MAX);
            if (r_presc == C_PRESC_MAX) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // PS/2 clock edge detection; data is sampled in the edge cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps2_clk_q <= 1'b1;
        end else begin
            r_ps2_clk_q <= ps2_clk_db;
        end
    end

    assign w_fall = r_ps2_clk_q & ~ps2_clk_db;

    // Timeout only matters mid-frame; a coincident edge overrides it.
    assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == C_TO_MAX);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && !ps2_data_db) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state = S_PARITY;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_next_state = S_STOP;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_next_state = S_IDLE;
                    w_frame_done = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame datapath: shift register, bit counter, parity capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!ps2_data_db) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    r_shift   <= {ps2_data_db, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                S_PARITY: begin
                    r_parity <= ps2_data_db;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter, saturating so it cannot wrap before the abort lands
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_state == S_IDLE)) begin
            r_to_cnt <= '0;
        end else if (r_tick && (r_to_cnt != C_TO_MAX)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and error reporting
    // ------------------------------------------------------------------
    assign w_parity_ok = ^{r_shift, r_parity};
    assign w_hold_free = !r_rx_valid || rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_err_code <= C_ERR_OVERRUN;
        end else begin
            r_rx_err <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_frame_done) begin
                // Stop-bit error outranks parity error.
                if (!ps2_data_db) begin
                    r_rx_err   <= 1'b1;
                    r_err_code <= C_ERR_STOP;
                end else if (!w_parity_ok) begin
                    r_rx_err   <= 1'b1;
                    r_err_code <= C_ERR_PARITY;
                end else if (!w_hold_free) begin
                    r_rx_err   <= 1'b1;
                    r_err_code <= C_ERR_OVERRUN;
                end else begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (w_abort) begin
                r_rx_err   <= 1'b1;
                r_err_code <= C_ERR_TIMEOUT;
            end
        end
    end

    assign deb_clock_enable = r_tick;
    assign rx_data          = r_rx_data;
    assign rx_valid         = r_rx_valid;
    assign rx_err           = r_rx_err;
    assign err_code         = r_err_code;
    assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_rx_ctrl
// Description : Self-checking bench for ps2_rx_ctrl. Frames are built from
//               bytes, parity and stop values; a frame-level model predicts
//               delivered bytes and error codes, which are compared against
//               what a monitor observes on the consumer interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_ctrl;

    localparam int TICK_DIV      = 4;
    localparam int TIMEOUT_TICKS = 20;
    localparam int HALF          = 10;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       ps2_clk_db  = 1'b1;
    logic       ps2_data_db = 1'b1;
    logic       rx_ready    = 1'b0;
    logic       deb_clock_enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_code;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];
    logic [1:0] got_errs[$];
    logic [1:0] exp_errs[$];

    logic       m_full = 1'b0;
    logic [7:0] m_data = 8'h00;

    ps2_rx_ctrl #(
        .TICK_DIV      (TICK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ps2_clk_db       (ps2_clk_db),
        .ps2_data_db      (ps2_data_db),
        .deb_clock_enable (deb_clock_enable),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .rx_err           (rx_err),
        .err_code         (err_code),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Observe the consumer interface between active edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got_bytes.push_back(rx_data);
            if (rx_err) got_errs.push_back(err_code);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data_db = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk_db = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk_db = 1'b1;
    endtask

    // bits[0] goes out first (the start bit).
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bits({stop, par, b, 1'b0}, 11);
        if (!stop)                       exp_errs.push_back(2'b10);
        else if (^{b, par} == 1'b0)      exp_errs.push_back(2'b01);
        else if (m_full && !rx_ready)    exp_errs.push_back(2'b00);
        else if (rx_ready)               exp_bytes.push_back(b);
        else begin
            m_full = 1'b1;
            m_data = b;
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
        if (v && m_full) begin
            exp_bytes.push_back(m_data);
            m_full = 1'b0;
        end
    endtask

    task automatic compare_sb(input string tag);
        repeat (6) @(posedge clk);
        #1;
        check_eq($sformatf("%s.nbytes", tag), got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check_eq($sformatf("%s.byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
        check_eq($sformatf("%s.nerrs", tag), got_errs.size(), exp_errs.size());
        for (int i = 0; i < exp_errs.size() && i < got_errs.size(); i++)
            check_eq($sformatf("%s.err%0d", tag, i), got_errs[i], exp_errs[i]);
        got_bytes.delete();
        exp_bytes.delete();
        got_errs.delete();
        exp_errs.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".tick"},     deb_clock_enable, 1'b0);
        check_eq({tag, ".rx_data"},  rx_data, 8'h00);
        check_eq({tag, ".rx_valid"}, rx_valid, 1'b0);
        check_eq({tag, ".rx_err"},   rx_err, 1'b0);
        check_eq({tag, ".err_code"}, err_code, 2'b00);
        check_eq({tag, ".busy"},     busy, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        int         k;

        // Reset state and strobe cadence after release.
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1 check_eq($sformatf("tick_c%0d", n), deb_clock_enable, (n % TICK_DIV) == 0);
        end

        // Directed frames.
        set_ready(1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        compare_sb("good_1c");
        check_eq("good_1c.valid_cleared", rx_valid, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1);
        compare_sb("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b0);
        compare_sb("bad_stop");
        check_eq("bad_stop.valid", rx_valid, 1'b0);

        // Overrun with a stalled consumer.
        set_ready(1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        compare_sb("overrun");
        check_eq("overrun.rx_data",  rx_data, 8'h1C);
        check_eq("overrun.rx_valid", rx_valid, 1'b1);
        check_eq("overrun.err_code", err_code, 2'b00);
        set_ready(1'b1);
        compare_sb("overrun_drain");

        // Timeout after a partial frame.
        send_bits({2'b11, 8'h0A, 1'b0}, 5);
        check_eq("timeout.busy_mid", busy, 1'b1);
        for (k = 0; k < 1000 && got_errs.size() == 0; k++) @(posedge clk);
        #1;
        check_eq("timeout.bounded", k < 1000, 1'b1);
        exp_errs.push_back(2'b11);
        check_eq("timeout.busy", busy, 1'b0);
        compare_sb("timeout");
        send_frame(8'h1C, 1'b0, 1'b1);
        compare_sb("after_timeout");

        // Reset in the middle of a frame.
        send_bits({2'b11, 8'h05, 1'b0}, 5);
        check_eq("midrst.busy_mid", busy, 1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk) rst_n = 1'b1;
        repeat (200) @(posedge clk);
        compare_sb("midrst_quiet");
        send_frame(8'h1C, 1'b0, 1'b1);
        compare_sb("after_midrst");

        // Randomized frames: good, bad parity, bad stop.
        for (int t = 0; t < 20; t++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 3);
            repeat ($urandom_range(1, 15)) @(posedge clk);
            #1;
            send_frame(b, (~^b) ^ (kind == 1), kind != 2);
            compare_sb($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
